// File: rtl/vec_alu_sequencer_if.sv
// Command, register-file and ALU-control bundle between the issue stage and vec_alu_sequencer.
// The master side issues commands and stalls; the slave side is the sequencer.
interface vec_alu_sequencer_if #(
  parameter int AW = 8,
  parameter int LW = 5
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_src_a;
  logic [AW-1:0] cmd_src_b;
  logic [AW-1:0] cmd_dst;
  logic [LW-1:0] cmd_len;
  logic          stall;
  logic          rd_en;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [1:0]    alu_selec;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;

  modport master (
    output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, stall,
    input  cmd_ready, rd_en, rd_addr_a, rd_addr_b, alu_selec, wr_en, wr_addr, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, stall,
    output cmd_ready, rd_en, rd_addr_a, rd_addr_b, alu_selec, wr_en, wr_addr, busy, done
  );
endinterface

// File: rtl/vec_alu_sequencer.sv
// Walks one vector ALU command across the register file a group per cycle:
// paired operand reads, ALU op select, and a one-cycle-delayed writeback.
module vec_alu_sequencer #(
  parameter int AW = 8,
  parameter int LW = 5
) (
  input  logic clk,
  input  logic rst_n,
  vec_alu_sequencer_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_reg, state_next;
  logic [1:0]    op_reg;
  logic [AW-1:0] addr_a_reg;
  logic [AW-1:0] addr_b_reg;
  logic [AW-1:0] dst_reg;
  logic [LW-1:0] cnt_reg;
  logic          wr_en_reg;
  logic [AW-1:0] wr_addr_reg;
  logic          accept;
  logic          issue;

  assign accept = bus.cmd_valid && (state_reg == S_IDLE);
  // Read issue follows stall combinationally so a busy port costs exactly one cycle.
  assign issue  = (state_reg == S_RUN) && !bus.stall;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          state_next = (bus.cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue && (cnt_reg == LW'(1))) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_IDLE;
      op_reg      <= '0;
      addr_a_reg  <= '0;
      addr_b_reg  <= '0;
      dst_reg     <= '0;
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg     <= bus.cmd_op;
        addr_a_reg <= bus.cmd_src_a;
        addr_b_reg <= bus.cmd_src_b;
        dst_reg    <= bus.cmd_dst;
        cnt_reg    <= bus.cmd_len;
      end else if (issue) begin
        // Address arithmetic wraps naturally at 2^AW.
        addr_a_reg <= addr_a_reg + AW'(1);
        addr_b_reg <= addr_b_reg + AW'(1);
        dst_reg    <= dst_reg + AW'(1);
        cnt_reg    <= cnt_reg - LW'(1);
      end
      // Writeback trails the read by one cycle to line up with register-file read data.
      wr_en_reg <= issue;
      if (issue) begin
        wr_addr_reg <= dst_reg;
      end
    end
  end

  assign bus.cmd_ready = (state_reg == S_IDLE);
  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.done      = (state_reg == S_DONE);
  assign bus.rd_en     = issue;
  assign bus.rd_addr_a = addr_a_reg;
  assign bus.rd_addr_b = addr_b_reg;
  assign bus.alu_selec = op_reg;
  assign bus.wr_en     = wr_en_reg;
  assign bus.wr_addr   = wr_addr_reg;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Randomised bench for vec_alu_sequencer against a per-command reference of read/write order and timing.
module tb_vec_alu_sequencer;
  localparam int AW = 8;
  localparam int LW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vec_alu_sequencer_if #(.AW(AW), .LW(LW)) bus ();
  vec_alu_sequencer #(.AW(AW), .LW(LW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] last_op = 2'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"}, 32'(bus.cmd_ready), 1);
    chk({pfx, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({pfx, "_wr_en"}, 32'(bus.wr_en), 0);
    chk({pfx, "_done"},  32'(bus.done), 0);
    chk({pfx, "_busy"},  32'(bus.busy), 0);
    chk({pfx, "_alu"},   32'(bus.alu_selec), 0);
    chk({pfx, "_rda"},   32'(bus.rd_addr_a), 0);
    chk({pfx, "_rdb"},   32'(bus.rd_addr_b), 0);
    chk({pfx, "_wra"},   32'(bus.wr_addr), 0);
  endtask

  // Presents one command, then follows it cycle by cycle. Reference: read i happens on the
  // (i+1)-th unstalled cycle after accept, its write one cycle later, done two cycles after the last read.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] d, input logic [4:0] len,
                         input logic [63:0] smask, input int spct, input logic hold,
                         input logic [1:0] nop, input logic [7:0] na, input logic [7:0] nb,
                         input logic [7:0] nd, input logic [4:0] nlen, output int waited);
    int reads, nrd, nwr, done_k, k;
    logic pend, exp_rd, fin;
    logic [7:0] pend_addr;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_src_a = a;
    bus.cmd_src_b = b;
    bus.cmd_dst   = d;
    bus.cmd_len   = len;
    for (waited = 0; waited < 50; waited++) begin
      bus.stall = 1'($urandom_range(1));
      @(negedge clk);
      chk("idle_alu", 32'(bus.alu_selec), 32'(last_op));
      if (bus.cmd_ready) break;
      @(posedge clk); #1;
    end
    chk("accept_ready", 32'(bus.cmd_ready), 1);
    if (!bus.cmd_ready) return;
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
    chk("idle_rd_en", 32'(bus.rd_en), 0);
    chk("idle_wr_en", 32'(bus.wr_en), 0);
    @(posedge clk); #1;
    if (hold) begin
      bus.cmd_op = nop; bus.cmd_src_a = na; bus.cmd_src_b = nb;
      bus.cmd_dst = nd; bus.cmd_len = nlen;
    end else begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 2'($urandom); bus.cmd_src_a = 8'($urandom); bus.cmd_src_b = 8'($urandom);
      bus.cmd_dst = 8'($urandom); bus.cmd_len = 5'($urandom);
    end
    last_op = op;
    reads = 0; nrd = 0; nwr = 0; pend = 1'b0; pend_addr = 8'd0;
    done_k = (len == 0) ? 0 : -1;
    fin = 1'b0;
    for (k = 0; k < 400 && !fin; k++) begin
      bus.stall = ((k < 64) && smask[k]) || (int'($urandom_range(99)) < spct);
      @(negedge clk);
      exp_rd = (reads < int'(len)) && !bus.stall;
      chk("rd_en", 32'(bus.rd_en), 32'(exp_rd));
      if (exp_rd) begin
        chk("rd_addr_a", 32'(bus.rd_addr_a), 32'(8'(a + 8'(reads))));
        chk("rd_addr_b", 32'(bus.rd_addr_b), 32'(8'(b + 8'(reads))));
      end
      chk("wr_en", 32'(bus.wr_en), 32'(pend));
      if (pend) chk("wr_addr", 32'(bus.wr_addr), 32'(pend_addr));
      chk("done", 32'(bus.done), 32'(k == done_k));
      chk("busy", 32'(bus.busy), 1);
      chk("cmd_ready", 32'(bus.cmd_ready), 0);
      chk("alu_selec", 32'(bus.alu_selec), 32'(op));
      if (bus.rd_en) nrd++;
      if (bus.wr_en) nwr++;
      pend = exp_rd;
      pend_addr = 8'(d + 8'(reads));
      if (exp_rd) begin
        reads++;
        if (reads == int'(len)) done_k = k + 2;
      end
      fin = (k == done_k);
      @(posedge clk); #1;
    end
    if (!fin) chk("done_timeout", 0, 1);
    chk("rd_count", 32'(nrd), 32'(len));
    chk("wr_count", 32'(nwr), 32'(len));
    $display("cmd op=%0d a=%02h b=%02h d=%02h len=%0d reads=%0d writes=%0d cycles=%0d",
             op, a, b, d, len, nrd, nwr, k);
    bus.stall = 1'b0;
  endtask

  initial begin
    int w;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_src_a = 8'd0; bus.cmd_src_b = 8'd0;
    bus.cmd_dst = 8'd0; bus.cmd_len = 5'd0; bus.stall = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_cmd(2'd2, 8'h10, 8'h20, 8'h30, 5'd4, 64'h0, 0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 5'd0, w);
    run_cmd(2'd2, 8'h10, 8'h20, 8'h30, 5'd4, 64'h6, 0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 5'd0, w);
    run_cmd(2'd1, 8'hFE, 8'hFF, 8'hFF, 5'd3, 64'h0, 0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 5'd0, w);

    // Zero length with a second command held on the bus.
    run_cmd(2'd3, 8'h40, 8'h50, 8'h60, 5'd0, 64'h0, 0, 1'b1, 2'd1, 8'h70, 8'h80, 8'h90, 5'd1, w);
    run_cmd(2'd1, 8'h70, 8'h80, 8'h90, 5'd1, 64'h0, 0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 5'd0, w);
    chk("b2b_wait", 32'(w), 0);

    // Asynchronous reset in the middle of a len=8 command.
    bus.cmd_valid = 1'b1; bus.cmd_op = 2'd3; bus.cmd_src_a = 8'h05; bus.cmd_src_b = 8'h15;
    bus.cmd_dst = 8'h25; bus.cmd_len = 5'd8; bus.stall = 1'b0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 1);
    chk("mid_wr_en", 32'(bus.wr_en), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async");
    @(posedge clk);
    @(negedge clk);
    chk_reset_vals("hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_op = 2'd0;
    run_cmd(2'd2, 8'hA0, 8'hB0, 8'hC0, 5'd2, 64'h0, 0, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 5'd0, w);

    run_cmd(2'd0, 8'hE0, 8'h30, 8'hF0, 5'd31, 64'h0, 30, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 5'd0, w);

    for (int i = 0; i < 15; i++) begin
      run_cmd(2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 5'($urandom),
              64'h0, $urandom_range(60), 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 5'd0, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
